// File: rtl/rtc_pkg.sv
// Shared types, digit limits and helper functions for the BCD real-time clock.
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t ms_hr;
    bcd_t ls_hr;
    bcd_t ms_min;
    bcd_t ls_min;
    bcd_t ms_sec;
    bcd_t ls_sec;
  } rtc_time_t;

  localparam bcd_t       DIGIT_MAX_9 = 4'd9;
  localparam bcd_t       DIGIT_MAX_5 = 4'd5;
  localparam logic [7:0] HOUR_MAX    = 8'd23;

  // 24-hour BCD hour pair to 12-hour BCD pair: 00->12, 13..23->01..11.
  function automatic logic [7:0] to_12h(input bcd_t ms, input bcd_t ls);
    logic [4:0] h24;
    logic [4:0] h12;
    h24 = 5'(ms) * 5'd10 + 5'(ls);
    if (h24 == 5'd0)
      h12 = 5'd12;
    else if (h24 > 5'd12)
      h12 = h24 - 5'd12;
    else
      h12 = h24;
    if (h12 >= 5'd10)
      to_12h = {4'd1, 4'(h12 - 5'd10)};
    else
      to_12h = {4'd0, 4'(h12)};
  endfunction

  function automatic logic load_valid(input rtc_time_t t);
    logic [7:0] hr;
    hr = 8'(t.ms_hr) * 8'd10 + 8'(t.ls_hr);
    return (t.ms_hr <= DIGIT_MAX_9) && (t.ls_hr <= DIGIT_MAX_9) &&
           (t.ms_min <= DIGIT_MAX_5) && (t.ls_min <= DIGIT_MAX_9) &&
           (t.ms_sec <= DIGIT_MAX_5) && (t.ls_sec <= DIGIT_MAX_9) &&
           (hr <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/rtc_bcd_digit.sv
// One BCD digit that wraps at MAX; carry_o fires on the increment that wraps it.
module rtc_bcd_digit
  import rtc_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX_9
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  input  logic clear_i,
  input  logic load_i,
  input  bcd_t ld_val_i,
  output bcd_t value_o,
  output logic carry_o
);

  bcd_t value_q;
  bcd_t value_d;

  // NOTE: default assignment first so every path drives value_d and no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (load_i)
      value_d = ld_val_i;
    else if (clear_i)
      value_d = '0;
    else if (inc_i)
      value_d = (value_q == MAX) ? '0 : value_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignment; reset is synchronous here.
  always_ff @(posedge clock) begin
    if (reset)
      value_q <= '0;
    else
      value_q <= value_d;
  end

  assign value_o = value_q;
  assign carry_o = inc_i && !load_i && !clear_i && (value_q == MAX);

endmodule

// File: rtl/rtc_bcd_counter.sv
// HH:MM:SS BCD clock with prescaler, 12/24-hour display and validated load.
// Optional alarm compare is compiled in when RTC_ALARM_EN is defined.
module rtc_bcd_counter
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [3:0] ld_ms_hr,
  input  logic [3:0] ld_ls_hr,
  input  logic [3:0] ld_ms_min,
  input  logic [3:0] ld_ls_min,
  input  logic [3:0] ld_ms_sec,
  input  logic [3:0] ld_ls_sec,
`ifdef RTC_ALARM_EN
  input  logic       al_set,
  input  logic [3:0] al_ms_hr,
  input  logic [3:0] al_ls_hr,
  input  logic [3:0] al_ms_min,
  input  logic [3:0] al_ls_min,
  input  logic       al_arm,
  output logic       alarm,
`endif
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic [3:0] ms_sec,
  output logic [3:0] ls_sec,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int                 CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLK_HZ - 1);

  rtc_time_t         ld_time;
  logic              load_ok;
  logic              tick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bcd_t              hr_ms_q, hr_ms_d, hr_ls_q, hr_ls_d;
  bcd_t              min_ms_v, min_ls_v, sec_ms_v, sec_ls_v;
  logic              c_sec_ls, c_sec_ms, c_min_ls, min_carry;
  logic              hour_wrap;
  logic              sec_tick_q, day_wrap_q, load_err_q;
  logic [7:0]        hr_disp;

  assign ld_time   = {ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min, ld_ms_sec, ld_ls_sec};
  assign load_ok   = load && load_valid(ld_time);
  // Any load strobe, accepted or not, swallows a coincident tick.
  assign tick      = enable && !load && (cnt_q == CNT_MAX);
  assign hour_wrap = (hr_ms_q == 4'd2) && (hr_ls_q == 4'd3);

  always_comb begin
    cnt_d = cnt_q;
    if (load_ok)
      cnt_d = '0;
    else if (!load && enable)
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  rtc_bcd_digit #(.MAX(DIGIT_MAX_9)) u_sec_ls (
    .clock, .reset, .inc_i(tick), .clear_i(1'b0), .load_i(load_ok),
    .ld_val_i(ld_ls_sec), .value_o(sec_ls_v), .carry_o(c_sec_ls));
  rtc_bcd_digit #(.MAX(DIGIT_MAX_5)) u_sec_ms (
    .clock, .reset, .inc_i(c_sec_ls), .clear_i(1'b0), .load_i(load_ok),
    .ld_val_i(ld_ms_sec), .value_o(sec_ms_v), .carry_o(c_sec_ms));
  rtc_bcd_digit #(.MAX(DIGIT_MAX_9)) u_min_ls (
    .clock, .reset, .inc_i(c_sec_ms), .clear_i(1'b0), .load_i(load_ok),
    .ld_val_i(ld_ls_min), .value_o(min_ls_v), .carry_o(c_min_ls));
  rtc_bcd_digit #(.MAX(DIGIT_MAX_5)) u_min_ms (
    .clock, .reset, .inc_i(c_min_ls), .clear_i(1'b0), .load_i(load_ok),
    .ld_val_i(ld_ms_min), .value_o(min_ms_v), .carry_o(min_carry));

  // Hours wrap at 23, so the pair is handled as one unit rather than two digits.
  always_comb begin
    hr_ms_d = hr_ms_q;
    hr_ls_d = hr_ls_q;
    if (load_ok) begin
      hr_ms_d = ld_ms_hr;
      hr_ls_d = ld_ls_hr;
    end else if (min_carry) begin
      if (hour_wrap) begin
        hr_ms_d = '0;
        hr_ls_d = '0;
      end else if (hr_ls_q == DIGIT_MAX_9) begin
        hr_ms_d = hr_ms_q + 4'd1;
        hr_ls_d = '0;
      end else begin
        hr_ls_d = hr_ls_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      hr_ms_q    <= '0;
      hr_ls_q    <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hr_ms_q    <= hr_ms_d;
      hr_ls_q    <= hr_ls_d;
      sec_tick_q <= tick;
      day_wrap_q <= min_carry && hour_wrap;
      load_err_q <= load && !load_ok;
    end
  end

  assign hr_disp  = mode_12h ? to_12h(hr_ms_q, hr_ls_q) : {hr_ms_q, hr_ls_q};
  assign ms_hr    = hr_disp[7:4];
  assign ls_hr    = hr_disp[3:0];
  assign ms_min   = min_ms_v;
  assign ls_min   = min_ls_v;
  assign ms_sec   = sec_ms_v;
  assign ls_sec   = sec_ls_v;
  assign pm       = (hr_ms_q == 4'd2) || ((hr_ms_q == 4'd1) && (hr_ls_q >= 4'd2));
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

`ifdef RTC_ALARM_EN
  bcd_t al_ms_hr_q, al_ls_hr_q, al_ms_min_q, al_ls_min_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      al_ms_hr_q  <= '0;
      al_ls_hr_q  <= '0;
      al_ms_min_q <= '0;
      al_ls_min_q <= '0;
    end else if (al_set) begin
      al_ms_hr_q  <= al_ms_hr;
      al_ls_hr_q  <= al_ls_hr;
      al_ms_min_q <= al_ms_min;
      al_ls_min_q <= al_ls_min;
    end
  end

  // sec_tick_q is never set by a load, so loads cannot raise the alarm.
  assign alarm = sec_tick_q && al_arm && (sec_ms_v == '0) && (sec_ls_v == '0) &&
                 ({hr_ms_q, hr_ls_q, min_ms_v, min_ls_v} ==
                  {al_ms_hr_q, al_ls_hr_q, al_ms_min_q, al_ls_min_q});
`endif

endmodule
